dotp_share_arb: RTL and testbench

Round-robin arbiter and scheduler that time-shares one pipelined fixed-point dot-product unit among `NREQ` requesters, e.g. the FIR-tap and spline-basis dot products of a spline adaptive filter. It accepts one operand pair per cycle and registers it onto the shared unit's inputs. It tags each issue through a shadow pipeline matched to the unit's latency, then routes each result back to its originating requester. The datapath is never stalled; responses have no backpressure.

---
 rtl/dotp_share_arb.sv | 103 ++++++++++
 tb/tb_dotp_share_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dotp_share_arb.sv
// Round-robin scheduler time-sharing one pipelined dot-product unit among NREQ requesters.
// Define DOTP_ARB_FIXED_PRIO_EN for strict lowest-index-first priority instead of round-robin.
module dotp_share_arb #(
  parameter int WIDTH = 16,
  parameter int QP    = 12,
  parameter int LEN   = 8,
  parameter int NREQ  = 2,
  parameter int LAT   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*LEN*WIDTH-1:0] req_vec1_packed,
  input  logic [NREQ*LEN*WIDTH-1:0] req_vec2_packed,
  output logic [LEN*WIDTH-1:0]      dp_vec1_packed,
  output logic [LEN*WIDTH-1:0]      dp_vec2_packed,
  input  logic [WIDTH-1:0]          dp_result,
  output logic [NREQ-1:0]           resp_valid,
  output logic [WIDTH-1:0]          resp_data,
  output logic                      busy
);

  localparam int          VW = LEN * WIDTH;
  localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NR = NREQ;

  if (NREQ < 2 || NREQ > 4 || LAT < 1 || LAT > 16 || QP < 0 || QP >= WIDTH) begin : g_bad_cfg
    $error("dotp_share_arb: unsupported parameter combination");
  end

  logic [NREQ-1:0]        gnt;
  logic [IW-1:0]          gnt_idx;
  logic                   hs;
  logic [LAT:0]           tag_vld;
  logic [LAT:0][IW-1:0]   tag_idx;

`ifndef DOTP_ARB_FIXED_PRIO_EN
  logic [IW-1:0]          ptr;
  int unsigned            cand;
`endif

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
`ifdef DOTP_ARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < NR; i++) begin
      if (req_valid[IW'(i)] && gnt == '0) begin
        gnt[IW'(i)] = 1'b1;
        gnt_idx     = IW'(i);
      end
    end
`else
    cand = 0;
    // Search starts one past the last grant and wraps modulo NREQ.
    for (int unsigned off = 1; off <= NR; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= NR) cand = cand - NR;
      if (req_valid[IW'(cand)] && gnt == '0) begin
        gnt[IW'(cand)] = 1'b1;
        gnt_idx        = IW'(cand);
      end
    end
`endif
    if (reset) gnt = '0;
  end

  assign req_ready = gnt;
  assign hs        = |gnt;
  assign busy      = |tag_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_vec1_packed <= '0;
      dp_vec2_packed <= '0;
      resp_valid     <= '0;
      resp_data      <= '0;
      tag_vld        <= '0;
      tag_idx        <= '0;
`ifndef DOTP_ARB_FIXED_PRIO_EN
      ptr            <= IW'(NREQ - 1);
`endif
    end else begin
      if (hs) begin
        dp_vec1_packed <= req_vec1_packed[32'(gnt_idx) * VW +: VW];
        dp_vec2_packed <= req_vec2_packed[32'(gnt_idx) * VW +: VW];
`ifndef DOTP_ARB_FIXED_PRIO_EN
        ptr            <= gnt_idx;
`endif
      end
      // Tag pipeline shifts every cycle so its last stage lines up with dp_result.
      tag_vld <= {tag_vld[LAT-1:0], hs};
      tag_idx <= {tag_idx[LAT-1:0], gnt_idx};
      if (tag_vld[LAT]) begin
        resp_valid <= NREQ'(1) << tag_idx[LAT];
        resp_data  <= dp_result;
      end else begin
        resp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dotp_share_arb.sv
// Scoreboard bench for dotp_share_arb with a behavioural LAT-stage Q(QP) dot-product unit.
module tb_dotp_share_arb;

  localparam int WIDTH = 16;
  localparam int QP    = 12;
  localparam int LEN   = 8;
  localparam int NREQ  = 2;
  localparam int LAT   = 3;
  localparam int VW    = LEN * WIDTH;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid, req_ready, resp_valid;
  logic [NREQ*VW-1:0]   req_vec1_packed, req_vec2_packed;
  logic [VW-1:0]        dp_vec1_packed, dp_vec2_packed;
  logic [WIDTH-1:0]     dp_result, resp_data;
  logic                 busy;

  always #5 clk = ~clk;

  dotp_share_arb #(.WIDTH(WIDTH), .QP(QP), .LEN(LEN), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vec1_packed(req_vec1_packed), .req_vec2_packed(req_vec2_packed),
    .dp_vec1_packed(dp_vec1_packed), .dp_vec2_packed(dp_vec2_packed),
    .dp_result(dp_result),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
  );

  function automatic logic [WIDTH-1:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    longint acc = 0;
    for (int i = 0; i < LEN; i++)
      acc += longint'($signed(a[i*WIDTH +: WIDTH])) * longint'($signed(b[i*WIDTH +: WIDTH]));
    acc = acc >>> QP;
    return acc[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= dot(dp_vec1_packed, dp_vec2_packed);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_result = pipe[LAT-1];

  typedef struct { int due; int idx; logic [WIDTH-1:0] data; } exp_t;
  exp_t             sbq[$];
  exp_t             e;
  logic [WIDTH-1:0] exp_res [NREQ];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation, on its due cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL missing_resp: got none expected idx %0d data %0h at cycle %0d", sbq[0].idx, sbq[0].data, sbq[0].due);
      void'(sbq.pop_front());
    end
    if (resp_valid !== '0) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_resp: got resp_valid %0b data %0h expected none (cycle %0d)", resp_valid, resp_data, cyc);
      end else begin
        e = sbq.pop_front();
        chk("resp_valid", VW'(resp_valid), VW'(NREQ'(1) << e.idx));
        chk("resp_data", VW'(resp_data), VW'(e.data));
        chk("resp_cycle", VW'(cyc), VW'(e.due));
      end
    end
  end

  function automatic logic [VW-1:0] fill(input logic [WIDTH-1:0] v);
    logic [VW-1:0] r;
    for (int k = 0; k < LEN; k++) r[k*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] res);
    req_vec1_packed[i*VW +: VW] = fill(a);
    req_vec2_packed[i*VW +: VW] = fill(b);
    exp_res[i] = res;
  endtask

  task automatic step(input logic [NREQ-1:0] g, input int eb = -1);
    int gi;
    @(negedge clk);
    if (eb >= 0) chk("busy", VW'(busy), VW'(eb));
    chk("req_ready", VW'(req_ready), VW'(g));
    if (g != '0) begin
      gi = 0;
      for (int i = 0; i < NREQ; i++) if (g[i]) gi = i;
      sbq.push_back('{due: cyc + LAT + 2, idx: gi, data: exp_res[gi]});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    chk("ready_idle", VW'(req_ready), '0);
    chk("dp_vec1_hold", dp_vec1_packed, fill(a));
    chk("dp_vec2_hold", dp_vec2_packed, fill(b));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    req_valid = '0;
    for (int i = 0; i < LAT + 3; i++) step('0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_vec1_packed = '0;
    req_vec2_packed = '0;
    for (int i = 0; i < NREQ; i++) exp_res[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    // Handshake attempt while in reset must be refused and leave no tag behind.
    req_valid = '1;
    step('0);
    reset = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("busy_reset", VW'(busy), '0);
    chk("resp_valid_reset", VW'(resp_valid), '0);
    chk("resp_data_reset", VW'(resp_data), '0);
    chk("dp_vec1_reset", dp_vec1_packed, '0);
    chk("dp_vec2_reset", dp_vec2_packed, '0);
    @(posedge clk); #1;
    drain();

    // Single issue from requester 0.
    set_req(0, 16'h1000, 16'h0800, 16'h4000);
    req_valid = 2'b01;
    step(2'b01, 0);
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy_inflight", VW'(busy), VW'(1));
      if (k == 0) chk("dp_vec1_load", dp_vec1_packed, fill(16'h1000));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("busy_done", VW'(busy), '0);
    @(posedge clk); #1;
    drain();

    // Back-to-back issues from requester 1.
    req_valid = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      set_req(1, WIDTH'(16'h1000 * k), 16'h0200, WIDTH'(16'h1000 * k));
      step(2'b10);
    end
    drain();

    // Contention: both requesters valid for six cycles.
    set_req(0, 16'h1000, 16'h0800, 16'h4000);
    set_req(1, 16'h0800, 16'h0800, 16'h2000);
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
`ifdef DOTP_ARB_FIXED_PRIO_EN
      step(2'b01);
`else
      step((k % 2 == 0) ? 2'b01 : 2'b10);
`endif
    end
    drain();

    // Idle gaps: operands must hold while request inputs change underneath.
    set_req(0, 16'h1000, 16'h0100, 16'h0800);
    req_valid = 2'b01; step(2'b01); req_valid = '0;
    set_req(0, 16'h2000, 16'h0100, 16'h1000);
    idle(16'h1000, 16'h0100);
    req_valid = 2'b01; step(2'b01); req_valid = '0;
    set_req(0, 16'h3000, 16'h0100, 16'h1800);
    idle(16'h2000, 16'h0100);
    idle(16'h2000, 16'h0100);
    req_valid = 2'b01; step(2'b01); req_valid = '0;
    set_req(0, 16'h7777, 16'h7777, 16'h0000);
    idle(16'h3000, 16'h0100);
    drain();

    // Reset mid-flight: in-flight results are discarded, pointer returns home.
    set_req(0, 16'h1000, 16'h0800, 16'h4000);
    set_req(1, 16'h0800, 16'h0800, 16'h2000);
    req_valid = 2'b01;
    step(2'b01);
    step(2'b01);
    req_valid = '0;
    step('0);
    reset = 1'b1;
    req_valid = 2'b11;
    step('0, 1);
    sbq.delete();
    reset = 1'b0;
    step(2'b01, 0);
    drain();

    chk("scoreboard_empty", VW'(sbq.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
